// File: rtl/unified_mem_arbiter_pkg.sv
// Shared definitions for the unified memory arbiter.
// Contents: owner tag encoding, the data returned for out-of-range reads,
// the default starvation limit and the packed owner-tag record.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_H    = 2'd1,
        OWN_D    = 2'd2,
        OWN_I    = 2'd3
    } owner_e;

    localparam logic [31:0] RDATA_OOR        = 32'hDEADBEEF;
    localparam int          STARVE_LIMIT_DEF = 4;

    // Everything the response cycle needs to know about last cycle's grant.
    typedef struct packed {
        owner_e owner;
        logic   oor;
        logic   is_write;
    } tag_t;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Requester-side bus of the unified memory arbiter.
// Carries request/grant/response signals of the host (h_*), CPU data (d_*)
// and CPU instruction-fetch (i_*) ports. The master modport is the
// requester view, the slave modport is the arbiter view. I is read-only.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              h_req;
    logic [ADDR_W-1:0] h_addr;
    logic [3:0]        h_wen;
    logic [31:0]       h_wdata;
    logic              h_gnt;
    logic              h_rvalid;
    logic [31:0]       h_rdata;

    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic [3:0]        d_wen;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [31:0]       i_rdata;

    modport master (
        output h_req, h_addr, h_wen, h_wdata,
        output d_req, d_addr, d_wen, d_wdata,
        output i_req, i_addr,
        input  h_gnt, h_rvalid, h_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  i_gnt, i_rvalid, i_rdata
    );

    modport slave (
        input  h_req, h_addr, h_wen, h_wdata,
        input  d_req, d_addr, d_wen, d_wdata,
        input  i_req, i_addr,
        output h_gnt, h_rvalid, h_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output i_gnt, i_rvalid, i_rdata
    );
endinterface

// File: rtl/unified_mem_arbiter_prio.sv
// Combinational fixed-priority picker for the unified memory arbiter.
// Order: H, then I when starved, then D, then I. At most one pick is high.
// Ports: h_req/d_req/i_req requests in, starved flag in, h/d/i_gnt picks out.
module mem_arb_prio (
    input  logic h_req,
    input  logic d_req,
    input  logic i_req,
    input  logic starved,
    output logic h_gnt,
    output logic d_gnt,
    output logic i_gnt
);

    // Priority chain; a starved I only jumps D, never H.
    always_comb begin
        h_gnt = 1'b0;
        d_gnt = 1'b0;
        i_gnt = 1'b0;
        if (h_req) begin
            h_gnt = 1'b1;
        end else if (i_req && starved) begin
            i_gnt = 1'b1;
        end else if (d_req) begin
            d_gnt = 1'b1;
        end else if (i_req) begin
            i_gnt = 1'b1;
        end else begin
            h_gnt = 1'b0;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Unified SRAM arbiter: one single-port, 1-cycle-latency SRAM shared by the
// host/loader (H), CPU data (D) and CPU instruction fetch (I) ports.
// Ports: clk, rst_n (async active-low); bus = requester interface (slave
// view); mem_en/mem_addr/mem_wen/mem_wdata drive the SRAM in the grant cycle;
// mem_rdata returns the SRAM word the cycle after mem_en.
// The granted request goes to the SRAM combinationally; an owner tag steers
// the response to the right port one cycle later.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int MEM_WORDS    = 1024,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    unified_mem_arbiter_if.slave         bus,
    output logic                         mem_en,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
    output logic [3:0]                   mem_wen,
    output logic [31:0]                  mem_wdata,
    input  logic [31:0]                  mem_rdata
);

    localparam int                MEM_AW     = $clog2(MEM_WORDS);
    localparam logic [ADDR_W-1:0] BYTE_LIMIT = ADDR_W'(4 * MEM_WORDS);
    localparam logic [3:0]        LIMIT_C    = 4'(STARVE_LIMIT);

    logic              h_pick_s, d_pick_s, i_pick_s;
    logic              starved_s;
    logic [3:0]        starve_cnt_r;
    owner_e            sel_own_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [3:0]        sel_wen_s;
    logic [31:0]       sel_wdata_s;
    logic              oor_s;
    tag_t              tag_r;
    logic [31:0]       resp_data_s;
    logic [31:0]       h_rdata_r, d_rdata_r, i_rdata_r;

    assign starved_s = (starve_cnt_r == LIMIT_C);

    mem_arb_prio u_prio (
        .h_req   (bus.h_req),
        .d_req   (bus.d_req),
        .i_req   (bus.i_req),
        .starved (starved_s),
        .h_gnt   (h_pick_s),
        .d_gnt   (d_pick_s),
        .i_gnt   (i_pick_s)
    );

    // No grant can escape while reset is asserted.
    assign bus.h_gnt = h_pick_s & rst_n;
    assign bus.d_gnt = d_pick_s & rst_n;
    assign bus.i_gnt = i_pick_s & rst_n;

    // Route the granted requester's command onto the shared SRAM path.
    always_comb begin
        sel_own_s   = OWN_NONE;
        sel_addr_s  = '0;
        sel_wen_s   = 4'b0000;
        sel_wdata_s = 32'h0000_0000;
        if (bus.h_gnt) begin
            sel_own_s   = OWN_H;
            sel_addr_s  = bus.h_addr;
            sel_wen_s   = bus.h_wen;
            sel_wdata_s = bus.h_wdata;
        end else if (bus.d_gnt) begin
            sel_own_s   = OWN_D;
            sel_addr_s  = bus.d_addr;
            sel_wen_s   = bus.d_wen;
            sel_wdata_s = bus.d_wdata;
        end else if (bus.i_gnt) begin
            sel_own_s   = OWN_I;
            sel_addr_s  = bus.i_addr;
        end else begin
            sel_own_s   = OWN_NONE;
        end
    end

    // Out-of-range accesses are granted but never reach the SRAM.
    assign oor_s     = (sel_addr_s >= BYTE_LIMIT);
    assign mem_en    = (sel_own_s != OWN_NONE) && !oor_s;
    assign mem_addr  = sel_addr_s[MEM_AW+1:2];
    assign mem_wen   = mem_en ? sel_wen_s : 4'b0000;
    assign mem_wdata = sel_wdata_s;

    // Capture who owns next cycle's response; an idle cycle leaves no owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_r <= '{owner: OWN_NONE, oor: 1'b0, is_write: 1'b0};
        end else begin
            tag_r <= '{owner: sel_own_s, oor: oor_s, is_write: (sel_wen_s != 4'b0000)};
        end
    end

    // Response payload for the current owner.
    always_comb begin
        if (tag_r.is_write) begin
            resp_data_s = 32'h0000_0000;
        end else if (tag_r.oor) begin
            resp_data_s = RDATA_OOR;
        end else begin
            resp_data_s = mem_rdata;
        end
    end

    // Per-port copy of the last response so non-owner rdata holds steady.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_rdata_r <= 32'h0000_0000;
            d_rdata_r <= 32'h0000_0000;
            i_rdata_r <= 32'h0000_0000;
        end else begin
            case (tag_r.owner)
                OWN_H:   h_rdata_r <= resp_data_s;
                OWN_D:   d_rdata_r <= resp_data_s;
                OWN_I:   i_rdata_r <= resp_data_s;
                default: h_rdata_r <= h_rdata_r;
            endcase
        end
    end

    assign bus.h_rvalid = (tag_r.owner == OWN_H);
    assign bus.d_rvalid = (tag_r.owner == OWN_D);
    assign bus.i_rvalid = (tag_r.owner == OWN_I);
    assign bus.h_rdata  = bus.h_rvalid ? resp_data_s : h_rdata_r;
    assign bus.d_rdata  = bus.d_rvalid ? resp_data_s : d_rdata_r;
    assign bus.i_rdata  = bus.i_rvalid ? resp_data_s : i_rdata_r;

    // Count D wins while I waits; H wins leave the count alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_r <= 4'd0;
        end else if (bus.i_gnt || !bus.i_req) begin
            starve_cnt_r <= 4'd0;
        end else if (bus.d_gnt && (starve_cnt_r != LIMIT_C)) begin
            starve_cnt_r <= starve_cnt_r + 4'd1;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: randomized requesters, a
// reference model of the arbitration rules and of memory contents, and a
// scoreboard queue drained by an independent response monitor.
module tb_unified_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W    = 32;
    localparam int MEM_WORDS = 1024;
    localparam int LIMIT     = 4;
    localparam int MEM_AW    = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    unified_mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
    logic              mem_en;
    logic [MEM_AW-1:0] mem_addr;
    logic [3:0]        mem_wen;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    unified_mem_arbiter #(.ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS), .STARVE_LIMIT(LIMIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_wen   (mem_wen),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    int n_chk  = 0;
    int n_fail = 0;

    function automatic logic [31:0] seed_word(int w);
        return (32'(w) * 32'h9E37_79B9) ^ 32'h1357_2468;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic str_chk(string nm, string act, string exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %s expected %s at %0t", nm, act, exp, $time);
        end
    endtask

    // SRAM behavioural model (1-cycle read latency, byte writes).
    logic [31:0] sram [MEM_WORDS];
    logic        sram_init;
    always @(posedge clk) begin
        if (sram_init !== 1'b1) begin
            for (int w = 0; w < MEM_WORDS; w++) sram[w] <= seed_word(w);
            sram_init <= 1'b1;
        end else if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_wen[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            mem_rdata <= sram[mem_addr];
        end
    end

    // Requester slots: index 0 = H, 1 = D, 2 = I.
    logic        pend    [3];
    logic [31:0] s_addr  [3];
    logic [3:0]  s_wen   [3];
    logic [31:0] s_wdata [3];
    int          rate    [3];
    bit          rd_only = 1'b0;
    bit          drop_en = 1'b0;
    int          pred_win = -1;

    typedef struct {
        int          who;
        logic [31:0] data;
    } resp_t;
    resp_t       exp_q [$];
    string       obs = "";
    logic [31:0] ref_mem [MEM_WORDS];
    bit          ref_init = 1'b0;
    int          starve_m = 0;
    logic [31:0] last_rd [3];

    task automatic apply();
        bus.h_req = pend[0]; bus.h_addr = s_addr[0]; bus.h_wen = s_wen[0]; bus.h_wdata = s_wdata[0];
        bus.d_req = pend[1]; bus.d_addr = s_addr[1]; bus.d_wen = s_wen[1]; bus.d_wdata = s_wdata[1];
        bus.i_req = pend[2]; bus.i_addr = s_addr[2];
    endtask

    task automatic gen(int p);
        logic [3:0] pats [10];
        pats = '{4'hF, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'h0, 4'h0, 4'h0};
        pend[p] = 1'b1;
        if ($urandom_range(0, 9) == 0)
            s_addr[p] = 32'h0000_1000 + 32'($urandom_range(0, 1023)) * 32'd4;
        else
            s_addr[p] = 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(0, 3));
        s_wen[p]   = (p == 2 || rd_only) ? 4'h0 : pats[$urandom_range(0, 9)];
        s_wdata[p] = $urandom;
    endtask

    task automatic put(int p, logic [31:0] a, logic [3:0] w, logic [31:0] d);
        pend[p] = 1'b1; s_addr[p] = a; s_wen[p] = w; s_wdata[p] = d;
        apply();
    endtask

    // One clock: retire the granted slot, maybe drop or issue requests.
    task automatic step();
        @(posedge clk);
        #1;
        for (int p = 0; p < 3; p++) begin
            if (pred_win == p) pend[p] = 1'b0;
            else if (pend[p] && drop_en && $urandom_range(0, 99) < 3) pend[p] = 1'b0;
            if (!pend[p] && int'($urandom_range(0, 99)) < rate[p]) gen(p);
        end
        apply();
    endtask

    task automatic drain();
        rate = '{0, 0, 0};
        drop_en = 1'b0;
        for (int k = 0; k < 20 && (pend[0] || pend[1] || pend[2]); k++) step();
        chk("drain_timeout", 32'({pend[2], pend[1], pend[0]}), 32'h0);
    endtask

    // Reference model: predicts the grant, the SRAM command and the response.
    always @(negedge clk) begin : model
        logic [2:0]  g;
        int          win;
        logic        oor, wr;
        logic [9:0]  word;
        logic [31:0] dat;
        string       tag;
        if (!ref_init) begin
            for (int w = 0; w < MEM_WORDS; w++) ref_mem[w] = seed_word(w);
            ref_init = 1'b1;
        end
        g   = {bus.i_gnt, bus.d_gnt, bus.h_gnt};
        tag = (g == 3'b001) ? "H" : (g == 3'b010) ? "D" : (g == 3'b100) ? "I" : "-";
        obs = {obs, tag};
        win = -1;
        if (!rst_n) begin
            chk("gnt_in_reset", 32'(g), 32'h0);
            chk("mem_en_in_reset", 32'(mem_en), 32'h0);
            starve_m = 0;
        end else begin
            if (pend[0]) win = 0;
            else if (pend[2] && starve_m == LIMIT) win = 2;
            else if (pend[1]) win = 1;
            else if (pend[2]) win = 2;
            chk("gnt", 32'(g), (win < 0) ? 32'h0 : (32'h1 << win));
            if (win >= 0) begin
                oor  = (s_addr[win] >= 32'(4 * MEM_WORDS));
                wr   = (win != 2) && (s_wen[win] != 4'h0);
                word = s_addr[win][MEM_AW+1:2];
                chk("mem_en", 32'(mem_en), 32'(!oor));
                if (!oor) begin
                    chk("mem_addr", 32'(mem_addr), 32'(word));
                    chk("mem_wen", 32'(mem_wen), (win == 2) ? 32'h0 : 32'(s_wen[win]));
                    if (wr) chk("mem_wdata", mem_wdata, s_wdata[win]);
                end
                if (wr) dat = 32'h0;
                else if (oor) dat = 32'hDEAD_BEEF;
                else dat = ref_mem[word];
                if (wr && !oor)
                    for (int b = 0; b < 4; b++)
                        if (s_wen[win][b]) ref_mem[word][b*8 +: 8] = s_wdata[win][b*8 +: 8];
                exp_q.push_back('{who: win, data: dat});
            end else begin
                chk("mem_en_idle", 32'(mem_en), 32'h0);
            end
            if (win == 2 || !pend[2]) starve_m = 0;
            else if (win == 1 && starve_m < LIMIT) starve_m++;
        end
        pred_win = win;
    end

    // Response monitor: pops the scoreboard whenever a response appears.
    always @(posedge clk) begin : monitor
        logic [2:0]  rv;
        logic [31:0] rd [3];
        resp_t       e;
        #2;
        rv    = {bus.i_rvalid, bus.d_rvalid, bus.h_rvalid};
        rd[0] = bus.h_rdata; rd[1] = bus.d_rdata; rd[2] = bus.i_rdata;
        if (!rst_n) begin
            exp_q.delete();
            chk("rvalid_in_reset", 32'(rv), 32'h0);
            for (int p = 0; p < 3; p++) last_rd[p] = 32'h0;
        end else if (rv != 3'b000) begin
            if (exp_q.size() == 0) begin
                chk("spurious_rvalid", 32'(rv), 32'h0);
            end else begin
                e = exp_q.pop_front();
                chk("rvalid_owner", 32'(rv), 32'h1 << e.who);
                chk("rdata", rd[e.who], e.data);
                last_rd[e.who] = e.data;
            end
        end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rvalid_missing", 32'(rv), 32'h1 << e.who);
        end
        for (int p = 0; p < 3; p++)
            if (!rv[p]) chk("rdata_hold", rd[p], last_rd[p]);
    end

    initial begin
        for (int p = 0; p < 3; p++) begin
            pend[p] = 1'b0; s_addr[p] = 32'h0; s_wen[p] = 4'h0; s_wdata[p] = 32'h0;
        end
        // Reset with every port requesting: nothing may be granted.
        rate = '{100, 100, 100};
        for (int p = 0; p < 3; p++) gen(p);
        apply();
        repeat (4) step();
        rst_n = 1'b1;
        obs   = "";
        rate  = '{0, 100, 100};
        step();
        str_chk("first_grant_after_reset", obs, "H");
        drain();

        // Host write then data read of the same word.
        put(0, 32'h0000_0200, 4'hF, 32'h0000_002A);
        step();
        put(1, 32'h0000_0200, 4'h0, 32'h0);
        @(negedge clk);
        chk("d_gnt_read", 32'(bus.d_gnt), 32'h1);
        chk("mem_addr_0x200", 32'(mem_addr), 32'h80);
        step();
        chk("d_rvalid_read", 32'(bus.d_rvalid), 32'h1);
        chk("d_rdata_read", bus.d_rdata, 32'h0000_002A);
        drain();

        // Out-of-range fetch.
        put(2, 32'h0000_1000, 4'h0, 32'h0);
        @(negedge clk);
        chk("oor_i_gnt", 32'(bus.i_gnt), 32'h1);
        chk("oor_mem_en", 32'(mem_en), 32'h0);
        step();
        chk("oor_i_rvalid", 32'(bus.i_rvalid), 32'h1);
        chk("oor_i_rdata", bus.i_rdata, 32'hDEAD_BEEF);
        drain();

        // Back-to-back: response of one grant overlaps the next grant.
        put(1, 32'h0000_0300, 4'hF, 32'h0000_0001);
        step();
        put(2, 32'h0000_0000, 4'h0, 32'h0);
        @(negedge clk);
        chk("b2b_d_rvalid", 32'(bus.d_rvalid), 32'h1);
        chk("b2b_i_gnt", 32'(bus.i_gnt), 32'h1);
        step();
        chk("b2b_i_rvalid", 32'(bus.i_rvalid), 32'h1);
        step();
        chk("b2b_no_extra", 32'({bus.i_rvalid, bus.d_rvalid, bus.h_rvalid}), 32'h0);
        drain();

        // Starvation guard with D and I requesting every cycle.
        rd_only = 1'b1;
        rate    = '{0, 100, 100};
        step();
        obs = "";
        repeat (10) step();
        str_chk("starve_seq", obs, "DDDDIDDDDI");
        // Two more D read grants, then reset during the D response cycle.
        repeat (2) step();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        obs = "";
        repeat (10) step();
        str_chk("starve_after_reset", obs, "DDDDIDDDDI");
        drain();
        rd_only = 1'b0;

        // Randomized traffic.
        drop_en = 1'b1;
        rate    = '{40, 70, 70};
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 49) == 0)
                for (int p = 0; p < 3; p++) rate[p] = int'($urandom_range(10, 95));
            step();
        end
        drain();
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
